// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready buffer with a registered i_ready and separate load enables for the head and skid registers.
// Optional synchronous flush port, enabled by defining RISCX_PIPE_FLUSH_EN.
module pipe_skid_buf #(
  parameter int unsigned    DW        = 32,
  parameter logic [DW-1:0]  RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef RISCX_PIPE_FLUSH_EN
  input  logic          flush,
`endif
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data
);

  // state | meaning
  // EMPTY | no beats held
  // ONE   | head register valid, skid empty
  // FULL  | head and skid both valid; upstream stalled
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] main_q, skid_q;
  logic          load_main, load_skid, main_from_skid;
  logic          accept, pop, flush_int;

`ifdef RISCX_PIPE_FLUSH_EN
  assign flush_int = flush;
`else
  assign flush_int = 1'b0;
`endif

  // Both handshake outputs decode straight from the state register.
  assign o_valid = (state != EMPTY);
  assign i_ready = (state != FULL);
  assign o_data  = main_q;

  assign accept = i_valid & i_ready;
  assign pop    = o_valid & o_ready;

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush_int) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_nxt      = ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= RESET_VAL;
    end else if (load_main) begin
      main_q <= main_from_skid ? skid_q : i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q <= RESET_VAL;
    end else if (load_skid) begin
      skid_q <= i_data;
    end
  end

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Directed-step bench for pipe_skid_buf: reset, streaming, backpressure, simultaneous push/pop,
// optional flush (RISCX_PIPE_FLUSH_EN) and asynchronous reset while full.
module tb_pipe_skid_buf;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          i_valid;
  logic          i_ready;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          o_ready;
  logic [DW-1:0] o_data;

  int n_chk  = 0;
  int n_pass = 0;

  pipe_skid_buf #(.DW(DW), .RESET_VAL('0)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef RISCX_PIPE_FLUSH_EN
    .flush   (flush),
`endif
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk3(input string tag, input logic ov, input logic ir, input logic [DW-1:0] od);
    chk({tag, ".o_valid"}, DW'(o_valid), DW'(ov));
    chk({tag, ".i_ready"}, DW'(i_ready), DW'(ir));
    if (ov) chk({tag, ".o_data"}, o_data, od);
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    flush   = 1'b0;
    rst_n   = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'hDEAD_BEEF;
    o_ready = 1'b0;
    #3;
    chk("rst.o_valid", DW'(o_valid), '0);
    chk("rst.i_ready", DW'(i_ready), DW'(1));
    chk("rst.o_data", o_data, '0);
    edge_step();
    chk("rst_edge.o_valid", DW'(o_valid), '0);
    chk("rst_edge.o_data", o_data, '0);
    rst_n = 1'b1;
    edge_step();
    chk3("first_accept", 1'b1, 1'b1, 32'hDEAD_BEEF);
    i_valid = 1'b0;
    o_ready = 1'b1;
    edge_step();
    chk3("drain0", 1'b0, 1'b1, '0);

    // streaming at full rate
    i_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      i_data = DW'(k);
      edge_step();
      chk3($sformatf("stream%0d", k), 1'b1, 1'b1, DW'(k));
    end
    i_valid = 1'b0;
    edge_step();
    chk3("stream_drain", 1'b0, 1'b1, '0);

    // backpressure
    o_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'hA;
    edge_step();
    chk3("bp_a", 1'b1, 1'b1, 32'hA);
    i_data = 32'hB;
    edge_step();
    chk3("bp_full", 1'b1, 1'b0, 32'hA);
    i_data = 32'hC;
    edge_step();
    chk3("bp_hold", 1'b1, 1'b0, 32'hA);
    o_ready = 1'b1;
    edge_step();
    chk3("bp_pop_a", 1'b1, 1'b1, 32'hB);
    edge_step();
    chk3("bp_pop_b", 1'b1, 1'b1, 32'hC);
    i_valid = 1'b0;
    edge_step();
    chk3("bp_pop_c", 1'b0, 1'b1, '0);

    // simultaneous accept and pop in ONE
    o_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'h5;
    edge_step();
    chk3("sim_load5", 1'b1, 1'b1, 32'h5);
    i_data  = 32'h6;
    o_ready = 1'b1;
    edge_step();
    chk3("sim_swap6", 1'b1, 1'b1, 32'h6);
    i_valid = 1'b0;
    edge_step();
    chk3("sim_drain", 1'b0, 1'b1, '0);

`ifdef RISCX_PIPE_FLUSH_EN
    o_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'h11;
    edge_step();
    i_data = 32'h22;
    edge_step();
    chk3("fl_full", 1'b1, 1'b0, 32'h11);
    i_valid = 1'b0;
    flush   = 1'b1;
    o_ready = 1'b1;
    edge_step();
    chk3("fl_flushed", 1'b0, 1'b1, '0);
    flush   = 1'b0;
    o_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'h33;
    edge_step();
    chk3("fl_33", 1'b1, 1'b1, 32'h33);
    i_data = 32'h44;
    edge_step();
    chk3("fl_44_full", 1'b1, 1'b0, 32'h33);
    i_valid = 1'b0;
    o_ready = 1'b1;
    edge_step();
    chk3("fl_pop33", 1'b1, 1'b1, 32'h44);
    edge_step();
    chk3("fl_empty", 1'b0, 1'b1, '0);
`endif

    // asynchronous reset while full
    o_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'h77;
    edge_step();
    i_data = 32'h88;
    edge_step();
    chk3("ar_full", 1'b1, 1'b0, 32'h77);
    i_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar.o_valid", DW'(o_valid), '0);
    chk("ar.i_ready", DW'(i_ready), DW'(1));
    chk("ar.o_data", o_data, '0);
    #2;
    rst_n = 1'b1;
    edge_step();
    chk3("ar_after", 1'b0, 1'b1, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
